// File: rtl/ervp_timer_sched_pkg.sv
// Shared types and constants for the timer scheduler.
package ervp_timer_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } sched_state_t;

  localparam int DEFAULT_BW_TIME = 32;

  // Largest delay that still compares correctly with the signed wrap-safe test.
  localparam logic [DEFAULT_BW_TIME-1:0] MAX_DELAY = {1'b0, {(DEFAULT_BW_TIME-1){1'b1}}};

endpackage

// File: rtl/ervp_timer_sched_slot.sv
// One timer channel: deadline, period, armed and periodic registers.
module ervp_timer_sched_slot #(
  parameter int BW_TIME = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm_en,
  input  logic [BW_TIME-1:0] arm_delay,
  input  logic               arm_periodic,
  input  logic               cancel_en,
  input  logic               hit_en,
  input  logic [BW_TIME-1:0] now,
  output logic [BW_TIME-1:0] deadline,
  output logic               armed
);

  logic [BW_TIME-1:0] period;
  logic               periodic;

  // Cancel beats arm and hit; arm beats reload; a hit reloads or disarms.
  always_ff @(posedge clk) begin
    if (rst) begin
      deadline <= '0;
      period   <= '0;
      periodic <= 1'b0;
      armed    <= 1'b0;
    end else if (cancel_en) begin
      armed <= 1'b0;
    end else if (arm_en) begin
      deadline <= now + arm_delay;
      period   <= arm_delay;
      periodic <= arm_periodic && (arm_delay != '0);
      armed    <= 1'b1;
    end else if (hit_en) begin
      if (periodic) begin
        deadline <= deadline + period;
      end else begin
        armed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ervp_timer_scheduler.sv
// Multi-channel software timer: shared time base, round-robin scanner and
// a single wrap-safe comparator feeding a sticky pending/interrupt stage.
module ervp_timer_scheduler
  import ervp_timer_sched_pkg::*;
#(
  parameter int  NUM_CH  = 4,
  parameter int  BW_TIME = DEFAULT_BW_TIME,
  localparam int BW_CH   = $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_1us,
  input  logic               arm_valid,
  output logic               arm_ready,
  input  logic [BW_CH-1:0]   arm_ch,
  input  logic [BW_TIME-1:0] arm_delay,
  input  logic               arm_periodic,
  input  logic               cancel_valid,
  input  logic [BW_CH-1:0]   cancel_ch,
  input  logic [NUM_CH-1:0]  ack,
  input  logic [NUM_CH-1:0]  irq_mask,
  output logic [NUM_CH-1:0]  expire_pulse,
  output logic [NUM_CH-1:0]  pending,
  output logic [NUM_CH-1:0]  armed,
  output logic               interrupt,
  output logic [BW_TIME-1:0] now
);

  localparam logic [BW_TIME-1:0] CLAMP_DELAY = {1'b0, {(BW_TIME-1){1'b1}}};
  localparam logic [BW_CH-1:0]   LAST_IDX    = BW_CH'(NUM_CH - 1);

  sched_state_t       state, state_next;
  logic [BW_CH-1:0]   idx, idx_next;
  logic [BW_TIME-1:0] deadline [NUM_CH];
  logic [BW_TIME-1:0] delay_clamped;
  logic [BW_TIME-1:0] elapsed;
  logic               hit_raw;
  logic               hit;
  logic               arm_accept;
  logic [NUM_CH-1:0]  set_vec;

  assign delay_clamped = arm_delay[BW_TIME-1] ? CLAMP_DELAY : arm_delay;

  // Wrap-safe test: the deadline has passed when now - deadline is non-negative.
  assign elapsed    = now - deadline[idx];
  assign hit_raw    = (state == SCAN) && armed[idx] && !elapsed[BW_TIME-1];
  assign hit        = hit_raw && !(cancel_valid && (cancel_ch == idx));
  assign arm_ready  = !(hit_raw && (arm_ch == idx));
  assign arm_accept = arm_valid && arm_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    ervp_timer_sched_slot #(
      .BW_TIME(BW_TIME)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .arm_en      (arm_accept && (arm_ch == BW_CH'(g))),
      .arm_delay   (delay_clamped),
      .arm_periodic(arm_periodic),
      .cancel_en   (cancel_valid && (cancel_ch == BW_CH'(g))),
      .hit_en      (hit && (idx == BW_CH'(g))),
      .now         (now),
      .deadline    (deadline[g]),
      .armed       (armed[g])
    );
  end

  // Free-running microsecond time base.
  always_ff @(posedge clk) begin
    if (rst) begin
      now <= '0;
    end else if (tick_1us) begin
      now <= now + BW_TIME'(1);
    end
  end

  // Scanner state and visit index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Scanner next state: idle holds idx, scan walks channels round-robin.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      IDLE: begin
        if (|armed) begin
          state_next = SCAN;
        end
      end
      SCAN: begin
        idx_next = (idx == LAST_IDX) ? '0 : idx + BW_CH'(1);
        if (armed == '0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One-hot set vector for the channel that expires this cycle.
  always_comb begin
    set_vec = '0;
    if (hit) begin
      set_vec[idx] = 1'b1;
    end
  end

  // Expiry pulse, sticky pending (set beats ack) and registered interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      expire_pulse <= '0;
      pending      <= '0;
      interrupt    <= 1'b0;
    end else begin
      expire_pulse <= set_vec;
      pending      <= (pending & ~ack) | set_vec;
      interrupt    <= |(pending & irq_mask);
    end
  end

endmodule

// File: tb/tb_ervp_timer_scheduler.sv
// Self-checking bench for ervp_timer_scheduler (4 channels, 8-bit time base
// so that the wrap point is reachable).
module tb_ervp_timer_scheduler;

  localparam int NCH = 4;
  localparam int BWT = 8;

  logic           clk;
  logic           rst;
  logic           tick_1us;
  logic           arm_valid;
  logic           arm_ready;
  logic [1:0]     arm_ch;
  logic [BWT-1:0] arm_delay;
  logic           arm_periodic;
  logic           cancel_valid;
  logic [1:0]     cancel_ch;
  logic [NCH-1:0] ack;
  logic [NCH-1:0] irq_mask;
  logic [NCH-1:0] expire_pulse;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] armed;
  logic           interrupt;
  logic [BWT-1:0] now;

  ervp_timer_scheduler #(
    .NUM_CH (NCH),
    .BW_TIME(BWT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_1us    (tick_1us),
    .arm_valid   (arm_valid),
    .arm_ready   (arm_ready),
    .arm_ch      (arm_ch),
    .arm_delay   (arm_delay),
    .arm_periodic(arm_periodic),
    .cancel_valid(cancel_valid),
    .cancel_ch   (cancel_ch),
    .ack         (ack),
    .irq_mask    (irq_mask),
    .expire_pulse(expire_pulse),
    .pending     (pending),
    .armed       (armed),
    .interrupt   (interrupt),
    .now         (now)
  );

  typedef struct {
    logic           arm_v;
    logic [1:0]     arm_c;
    logic [BWT-1:0] arm_d;
    logic           per;
    logic           can_v;
    logic [1:0]     can_c;
    logic [NCH-1:0] exp_armed;
  } vec_t;

  typedef struct {
    int             ch;
    logic [BWT-1:0] at_now;
    bit             chk_lat;
  } exp_t;

  vec_t vecs [8];
  exp_t sb [$];
  int   tests;
  int   failed;
  int   pulse_count [NCH];
  bit   tick_en;
  int   tick_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One tick every 10 cycles while enabled: every channel is visited between ticks.
  initial begin
    tick_1us = 1'b0;
    tick_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (tick_en) begin
        tick_cnt++;
        tick_1us = (tick_cnt % 10 == 0);
      end else begin
        tick_1us = 1'b0;
      end
    end
  end

  // Scoreboard consumer: every pulse must match the next expected expiry.
  initial begin
    int             cyc;
    int             now_since;
    logic [BWT-1:0] prev_now;
    exp_t           e;
    int             lat;
    cyc       = 0;
    now_since = 0;
    prev_now  = '0;
    for (int c = 0; c < NCH; c++) pulse_count[c] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (now !== prev_now) begin
        now_since = cyc;
        prev_now  = now;
      end
      for (int c = 0; c < NCH; c++) begin
        if (expire_pulse[c] === 1'b1) begin
          pulse_count[c]++;
          tests++;
          if (sb.size() == 0) begin
            failed++;
            $display("[TB] FAIL unexpected_pulse: ch%0d pulsed at now=%0d, expected no pulse", c, now);
          end else begin
            e   = sb.pop_front();
            lat = cyc - now_since;
            if (e.ch != c || e.at_now !== now || (e.chk_lat && (lat < 1 || lat > NCH + 1))) begin
              failed++;
              $display("[TB] FAIL pulse_match: got ch%0d now=%0d latency=%0d, expected ch%0d now=%0d latency 1..%0d",
                       c, now, lat, e.ch, e.at_now, NCH + 1);
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int i);
    arm_valid    = v.arm_v;
    arm_ch       = v.arm_c;
    arm_delay    = v.arm_d;
    arm_periodic = v.per;
    cancel_valid = v.can_v;
    cancel_ch    = v.can_c;
    #1;
    checkOutput($sformatf("vec%0d_ready", i), 32'(arm_ready), 32'd1);
    step();
    arm_valid    = 1'b0;
    cancel_valid = 1'b0;
    checkOutput($sformatf("vec%0d_armed", i), 32'(armed), 32'(v.exp_armed));
  endtask

  task automatic wait_now(input logic [BWT-1:0] target);
    int n;
    n = 0;
    while (now !== target && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) begin
      tests++;
      failed++;
      $display("[TB] FAIL wait_now_timeout: now=%0d, expected to reach %0d", now, target);
    end
  endtask

  task automatic wait_pulses(input int ch, input int n);
    int k;
    k = 0;
    while (pulse_count[ch] < n && k < 300) begin
      step();
      k++;
    end
    if (k >= 300) begin
      tests++;
      failed++;
      $display("[TB] FAIL wait_pulse_timeout: ch%0d count=%0d, expected %0d", ch, pulse_count[ch], n);
    end
  endtask

  task automatic wait_idx(input logic [1:0] target);
    int k;
    k = 0;
    while (dut.idx !== target && k < 20) begin
      step();
      k++;
    end
    if (k >= 20) begin
      tests++;
      failed++;
      $display("[TB] FAIL wait_idx_timeout: idx=%0d, expected %0d", dut.idx, target);
    end
  endtask

  task automatic arm_once(input logic [1:0] ch, input logic [BWT-1:0] d, input logic per);
    arm_valid    = 1'b1;
    arm_ch       = ch;
    arm_delay    = d;
    arm_periodic = per;
    step();
    arm_valid    = 1'b0;
    arm_periodic = 1'b0;
  endtask

  task automatic push_exp(input int ch, input logic [BWT-1:0] at, input bit chk);
    exp_t e;
    e.ch      = ch;
    e.at_now  = at;
    e.chk_lat = chk;
    sb.push_back(e);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    vecs[0] = '{1'b1, 2'd0, 8'd50, 1'b0, 1'b0, 2'd0, 4'b0001};
    vecs[1] = '{1'b1, 2'd1, 8'd50, 1'b0, 1'b0, 2'd0, 4'b0011};
    vecs[2] = '{1'b1, 2'd2, 8'd50, 1'b0, 1'b1, 2'd2, 4'b0011};
    vecs[3] = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b1, 2'd0, 4'b0010};
    vecs[4] = '{1'b1, 2'd3, 8'd60, 1'b0, 1'b1, 2'd1, 4'b1000};
    vecs[5] = '{1'b1, 2'd3, 8'd70, 1'b1, 1'b0, 2'd0, 4'b1000};
    vecs[6] = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b1, 2'd3, 4'b0000};
    vecs[7] = '{1'b0, 2'd0, 8'd0,  1'b0, 1'b0, 2'd0, 4'b0000};

    rst = 1'b1; tick_en = 1'b0;
    arm_valid = 1'b0; arm_ch = '0; arm_delay = '0; arm_periodic = 1'b0;
    cancel_valid = 1'b0; cancel_ch = '0; ack = '0; irq_mask = '0;
    step();
    step();
    checkOutput("reset_armed",   32'(armed),        32'd0);
    checkOutput("reset_now",     32'(now),          32'd0);
    checkOutput("reset_pending", 32'(pending),      32'd0);
    checkOutput("reset_pulse",   32'(expire_pulse), 32'd0);
    checkOutput("reset_irq",     32'(interrupt),    32'd0);
    checkOutput("reset_ready",   32'(arm_ready),    32'd1);
    rst = 1'b0;

    // Arm / cancel / re-arm table with time frozen.
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i], i);
    checkOutput("table_now_frozen", 32'(now), 32'd0);

    // Periodic channel 0, delay 3, armed at now=10; cancel after third pulse.
    tick_en = 1'b1;
    wait_now(8'd10);
    push_exp(0, 8'd13, 1'b1);
    push_exp(0, 8'd16, 1'b1);
    push_exp(0, 8'd19, 1'b1);
    arm_once(2'd0, 8'd3, 1'b1);
    checkOutput("periodic_armed", 32'(armed[0]), 32'd1);
    wait_pulses(0, 3);
    cancel_valid = 1'b1; cancel_ch = 2'd0;
    step();
    cancel_valid = 1'b0;
    checkOutput("periodic_cancelled", 32'(armed[0]), 32'd0);
    wait_now(8'd24);
    checkOutput("periodic_no_fourth", 32'(pulse_count[0]), 32'd3);

    // One-shot channel 2, delay 5 at now=100, with interrupt mask on ch2.
    irq_mask = 4'b0100;
    wait_now(8'd100);
    push_exp(2, 8'd105, 1'b1);
    arm_once(2'd2, 8'd5, 1'b0);
    wait_pulses(2, 1);
    checkOutput("oneshot_disarmed", 32'(armed[2]),  32'd0);
    checkOutput("oneshot_pending",  32'(pending[2]), 32'd1);
    checkOutput("oneshot_irq",      32'(interrupt),  32'd1);
    ack = 4'b0100;
    step();
    ack = '0;
    checkOutput("ack_clears", 32'(pending[2]), 32'd0);
    step();
    checkOutput("irq_drops", 32'(interrupt), 32'd0);

    // Arm request on ch3 during its hit: stalled one cycle, then new deadline used.
    wait_now(8'd110);
    push_exp(3, 8'd112, 1'b1);
    arm_once(2'd3, 8'd2, 1'b0);
    wait_now(8'd112);
    wait_idx(2'd3);
    arm_valid = 1'b1; arm_ch = 2'd3; arm_delay = 8'd5; arm_periodic = 1'b0;
    #1;
    checkOutput("conflict_ready_low", 32'(arm_ready), 32'd0);
    step();
    checkOutput("conflict_ready_high", 32'(arm_ready), 32'd1);
    push_exp(3, 8'd117, 1'b1);
    step();
    arm_valid = 1'b0;
    checkOutput("conflict_rearmed", 32'(armed[3]), 32'd1);
    wait_pulses(3, 2);

    // Cancel in the same cycle as the hit on ch1: no pulse, pending untouched.
    wait_now(8'd120);
    arm_once(2'd1, 8'd2, 1'b0);
    wait_now(8'd122);
    wait_idx(2'd1);
    cancel_valid = 1'b1; cancel_ch = 2'd1;
    step();
    cancel_valid = 1'b0;
    checkOutput("cancel_hit_armed",   32'(armed[1]),   32'd0);
    checkOutput("cancel_hit_pending", 32'(pending[1]), 32'd0);
    wait_now(8'd124);
    checkOutput("cancel_hit_nopulse", 32'(pulse_count[1]), 32'd0);

    // Ack together with a set on ch1: set wins; masked channel keeps irq low.
    wait_now(8'd130);
    push_exp(1, 8'd131, 1'b1);
    arm_once(2'd1, 8'd1, 1'b0);
    wait_pulses(1, 1);
    checkOutput("ch1_pending", 32'(pending[1]), 32'd1);
    checkOutput("masked_irq",  32'(interrupt),  32'd0);
    wait_now(8'd140);
    push_exp(1, 8'd142, 1'b1);
    arm_once(2'd1, 8'd2, 1'b0);
    wait_now(8'd142);
    wait_idx(2'd1);
    ack = 4'b0010;
    step();
    ack = '0;
    checkOutput("ack_vs_set", 32'(pending[1]), 32'd1);
    wait_pulses(1, 2);
    ack = 4'b0010;
    step();
    ack = '0;
    checkOutput("ack_alone", 32'(pending[1]), 32'd0);

    // Periodic with delay 0 behaves as one-shot and expires on the next visit.
    wait_now(8'd150);
    push_exp(0, 8'd150, 1'b0);
    arm_once(2'd0, 8'd0, 1'b1);
    wait_pulses(0, 4);
    for (int i = 0; i < 8; i++) step();
    checkOutput("zero_delay_disarmed", 32'(armed[0]),       32'd0);
    checkOutput("zero_delay_single",   32'(pulse_count[0]), 32'd4);

    // Wrap: armed at now=254 with delay 4 expires at now=2, not earlier.
    wait_now(8'd254);
    push_exp(1, 8'd2, 1'b1);
    arm_once(2'd1, 8'd4, 1'b0);
    wait_now(8'd1);
    checkOutput("wrap_no_early", 32'(pulse_count[1]), 32'd2);
    wait_pulses(1, 3);
    checkOutput("wrap_disarmed", 32'(armed[1]), 32'd0);

    // Clamp: delay 200 becomes 127 on an 8-bit time base.
    wait_now(8'd5);
    push_exp(2, 8'd132, 1'b1);
    arm_once(2'd2, 8'd200, 1'b0);
    for (int i = 0; i < 3; i++) step();
    checkOutput("clamp_armed", 32'(armed[2]), 32'd1);
    wait_now(8'd131);
    checkOutput("clamp_not_yet", 32'(pulse_count[2]), 32'd1);
    wait_pulses(2, 2);

    // Reset with all channels armed and an arm in flight.
    tick_en = 1'b0;
    step();
    for (int c = 0; c < NCH; c++) arm_once(2'(c), 8'd50, 1'b0);
    checkOutput("all_armed", 32'(armed), 32'hF);
    rst = 1'b1;
    arm_valid = 1'b1; arm_ch = 2'd0; arm_delay = 8'd3;
    step();
    rst = 1'b0;
    arm_valid = 1'b0;
    checkOutput("rst_armed",   32'(armed),     32'd0);
    checkOutput("rst_now",     32'(now),       32'd0);
    checkOutput("rst_ready",   32'(arm_ready), 32'd1);
    checkOutput("rst_pending", 32'(pending),   32'd0);
    checkOutput("rst_state",   32'(dut.state), 32'd0);
    step();
    checkOutput("rst_arm_lost", 32'(armed), 32'd0);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
